// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types and constants for the ghost movement blocks
// (position update and ghost control).
//   - direction one-hot encodings (RIGHT/UP/DOWN/LEFT)
//   - pixel position widths and default maze tile size
//   - FSM state type; the CAUGHT state only exists when GHOST_RESPAWN_EN is defined
package ghost_pkg;

   localparam int unsigned POS_X_W      = 11;
   localparam int unsigned POS_Y_W      = 10;
   localparam int unsigned DIR_W        = 4;
   localparam int unsigned TILE_DEFAULT = 16;

   typedef logic [DIR_W-1:0]   dir_t;
   typedef logic [POS_X_W-1:0] pos_x_t;
   typedef logic [POS_Y_W-1:0] pos_y_t;

   localparam dir_t DIR_RIGHT = 4'b0001;
   localparam dir_t DIR_UP    = 4'b0010;
   localparam dir_t DIR_DOWN  = 4'b0100;
   localparam dir_t DIR_LEFT  = 4'b1000;

`ifdef GHOST_RESPAWN_EN
   typedef enum logic [1:0] {
      ST_SAMPLE = 2'd0,
      ST_MOVE   = 2'd1,
      ST_CAUGHT = 2'd2
   } state_t;
`else
   typedef enum logic {
      ST_SAMPLE = 1'b0,
      ST_MOVE   = 1'b1
   } state_t;
`endif

   // True when exactly one request bit is set.
   function automatic logic is_one_hot(input dir_t d);
      return (d != '0) && ((d & (d - DIR_W'(1))) == '0);
   endfunction

endpackage : ghost_pkg

// File: rtl/ghost_pos_update_if.sv
// ghost_pos_update_if: bundle between ghost control (master) and the ghost
// position updater (slave).
//   master drives: enable, move_tick, move_direction, pacman_curr_pos_x/y
//   slave drives : ghost_curr_pos_x/y, prev_direction, caught
interface ghost_pos_update_if;
   import ghost_pkg::*;

   logic   enable;
   logic   move_tick;
   dir_t   move_direction;
   pos_x_t pacman_curr_pos_x;
   pos_y_t pacman_curr_pos_y;
   pos_x_t ghost_curr_pos_x;
   pos_y_t ghost_curr_pos_y;
   dir_t   prev_direction;
   logic   caught;

   modport master (
      output enable, move_tick, move_direction, pacman_curr_pos_x, pacman_curr_pos_y,
      input  ghost_curr_pos_x, ghost_curr_pos_y, prev_direction, caught
   );

   modport slave (
      input  enable, move_tick, move_direction, pacman_curr_pos_x, pacman_curr_pos_y,
      output ghost_curr_pos_x, ghost_curr_pos_y, prev_direction, caught
   );

endinterface : ghost_pos_update_if

// File: rtl/ghost_collide.sv
// ghost_collide: combinational ghost/pacman overlap test.
// Overlap when both absolute pixel distances are below one tile.
//   gx_i/gy_i  : ghost position
//   px_i/py_i  : pacman position
//   overlap_c  : combinational overlap flag
module ghost_collide
   import ghost_pkg::*;
#(
   parameter int unsigned TILE = TILE_DEFAULT
) (
   input  pos_x_t gx_i,
   input  pos_x_t px_i,
   input  pos_y_t gy_i,
   input  pos_y_t py_i,
   output logic   overlap_c
);

   pos_x_t dx_c;
   pos_y_t dy_c;

   always_comb begin
      dx_c      = (gx_i >= px_i) ? (gx_i - px_i) : (px_i - gx_i);
      dy_c      = (gy_i >= py_i) ? (gy_i - py_i) : (py_i - gy_i);
      overlap_c = (32'(dx_c) < TILE) && (32'(dy_c) < TILE);
   end

endmodule : ghost_collide

// File: rtl/ghost_pos_update.sv
// ghost_pos_update: tile-granular ghost movement with tunnel wrap on x and a
// registered ghost/pacman overlap flag.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : enable/move_tick/move_direction/pacman position in,
//                ghost position/prev_direction/caught out (all registered)
// A one-hot request in SAMPLE commits the ghost to a full TILE move; requests
// are ignored until the tile completes. TILE must be a multiple of STEP.
// Optional: define GHOST_RESPAWN_EN to add the CAUGHT state, which freezes the
// ghost for RESPAWN_TICKS move ticks and then sends it home.
module ghost_pos_update
   import ghost_pkg::*;
#(
   parameter pos_x_t      START_X       = 11'd320,
   parameter pos_y_t      START_Y       = 10'd240,
   parameter int unsigned TILE          = TILE_DEFAULT,
   parameter int unsigned STEP          = 1,
   parameter pos_x_t      X_MAX         = 11'd639,
   parameter int unsigned RESPAWN_TICKS = 60
) (
   input logic               clk,
   input logic               reset,
   ghost_pos_update_if.slave bus
);

   localparam int unsigned OFF_W = $clog2(TILE + 1);
   localparam int unsigned XE_W  = POS_X_W + 1;

   state_t             state_q, state_d;
   dir_t               cur_dir_q, cur_dir_d;
   dir_t               prev_q, prev_d;
   logic [OFF_W-1:0]   offset_q, offset_d;
   pos_x_t             x_q, x_d;
   pos_y_t             y_q, y_d;
   logic               caught_q;
   logic               overlap_c;
   logic               tick_c;
   logic               mv_go_c;
   logic               mv_en_c;
   dir_t               mv_dir_c;
   logic [OFF_W-1:0]   off_step_c;

   // x step with tunnel wrap at both screen edges
   function automatic pos_x_t step_x(input pos_x_t x, input dir_t d);
      logic [XE_W-1:0] xe;
      xe     = XE_W'(x);
      step_x = x;
      if (d == DIR_RIGHT) begin
         if (xe + XE_W'(STEP) > XE_W'(X_MAX))
            step_x = POS_X_W'(xe + XE_W'(STEP) - XE_W'(X_MAX) - XE_W'(1));
         else
            step_x = POS_X_W'(xe + XE_W'(STEP));
      end else if (d == DIR_LEFT) begin
         if (xe < XE_W'(STEP))
            step_x = POS_X_W'(XE_W'(X_MAX) + XE_W'(1) - XE_W'(STEP) + xe);
         else
            step_x = POS_X_W'(xe - XE_W'(STEP));
      end
   endfunction

   // y step, no wrap
   function automatic pos_y_t step_y(input pos_y_t y, input dir_t d);
      step_y = y;
      if (d == DIR_UP)        step_y = y - POS_Y_W'(STEP);
      else if (d == DIR_DOWN) step_y = y + POS_Y_W'(STEP);
   endfunction

   ghost_collide #(.TILE(TILE)) u_collide (
      .gx_i      (x_q),
      .px_i      (bus.pacman_curr_pos_x),
      .gy_i      (y_q),
      .py_i      (bus.pacman_curr_pos_y),
      .overlap_c (overlap_c)
   );

   // Movement qualifiers: SAMPLE takes a fresh one-hot request, MOVE keeps cur_dir
   always_comb begin
      tick_c     = bus.enable && bus.move_tick;
      mv_dir_c   = (state_q == ST_MOVE) ? cur_dir_q : bus.move_direction;
      mv_go_c    = tick_c && ((state_q == ST_MOVE) ||
                              ((state_q == ST_SAMPLE) && is_one_hot(bus.move_direction)));
      off_step_c = ((state_q == ST_MOVE) ? offset_q : '0) + OFF_W'(STEP);
   end

`ifdef GHOST_RESPAWN_EN
   localparam int unsigned RC_W = $clog2(RESPAWN_TICKS + 1);

   logic            caught_hist_q;
   logic [RC_W-1:0] resp_cnt_q, resp_cnt_d;
   logic            catch_c;

   // Rising edge of registered caught while the ghost is free to move
   assign catch_c = bus.enable && caught_q && !caught_hist_q &&
                    ((state_q == ST_SAMPLE) || (state_q == ST_MOVE));
   assign mv_en_c = mv_go_c && !catch_c;
`else
   assign mv_en_c = mv_go_c;
`endif

   // Next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      cur_dir_d = cur_dir_q;
      prev_d    = prev_q;
      offset_d  = offset_q;
      x_d       = x_q;
      y_d       = y_q;
`ifdef GHOST_RESPAWN_EN
      resp_cnt_d = resp_cnt_q;
`endif

      if (mv_en_c) begin
         cur_dir_d = mv_dir_c;
         x_d       = step_x(x_q, mv_dir_c);
         y_d       = step_y(y_q, mv_dir_c);
         if (off_step_c == OFF_W'(TILE)) begin
            offset_d = '0;
            prev_d   = mv_dir_c;
            state_d  = ST_SAMPLE;
         end else begin
            offset_d = off_step_c;
            state_d  = ST_MOVE;
         end
      end

`ifdef GHOST_RESPAWN_EN
      if (catch_c) begin
         state_d    = ST_CAUGHT;
         resp_cnt_d = '0;
      end

      if ((state_q == ST_CAUGHT) && tick_c) begin
         if (resp_cnt_q == RC_W'(RESPAWN_TICKS - 1)) begin
            resp_cnt_d = '0;
            x_d        = START_X;
            y_d        = START_Y;
            prev_d     = DIR_UP;
            offset_d   = '0;
            state_d    = ST_SAMPLE;
         end else begin
            resp_cnt_d = resp_cnt_q + RC_W'(1);
         end
      end
`endif
   end

   // State and position registers; caught samples every cycle regardless of enable
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_SAMPLE;
         cur_dir_q <= DIR_UP;
         prev_q    <= DIR_UP;
         offset_q  <= '0;
         x_q       <= START_X;
         y_q       <= START_Y;
         caught_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_dir_q <= cur_dir_d;
         prev_q    <= prev_d;
         offset_q  <= offset_d;
         x_q       <= x_d;
         y_q       <= y_d;
         caught_q  <= overlap_c;
      end
   end

`ifdef GHOST_RESPAWN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         caught_hist_q <= 1'b0;
         resp_cnt_q    <= '0;
      end else begin
         caught_hist_q <= caught_q;
         resp_cnt_q    <= resp_cnt_d;
      end
   end
`endif

   assign bus.ghost_curr_pos_x = x_q;
   assign bus.ghost_curr_pos_y = y_q;
   assign bus.prev_direction   = prev_q;
   assign bus.caught           = caught_q;

endmodule : ghost_pos_update

// File: tb/tb_ghost_pos_update.sv
// tb_ghost_pos_update: directed bench for ghost_pos_update with default
// parameters. Respawn checks are compiled in when GHOST_RESPAWN_EN is defined.
module tb_ghost_pos_update;
   import ghost_pkg::*;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   ghost_pos_update_if bus ();

   ghost_pos_update dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One enabled movement strobe; returns on the negedge after the active edge
   task automatic tick(input dir_t d);
      @(negedge clk);
      bus.move_direction = d;
      bus.move_tick      = 1'b1;
      @(negedge clk);
      bus.move_tick      = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd320) begin
         tests_failed++; $display("FAIL reset_x got %0d exp 320", bus.ghost_curr_pos_x);
      end
      tests_run++;
      if (bus.ghost_curr_pos_y !== 10'd240) begin
         tests_failed++; $display("FAIL reset_y got %0d exp 240", bus.ghost_curr_pos_y);
      end
      tests_run++;
      if (bus.prev_direction !== 4'b0010) begin
         tests_failed++; $display("FAIL reset_prev got %b exp 0010", bus.prev_direction);
      end
      tests_run++;
      if (bus.caught !== 1'b0) begin
         tests_failed++; $display("FAIL reset_caught got %b exp 0", bus.caught);
      end
   endtask

   task automatic test_right_tile();
      tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd321) begin
         tests_failed++; $display("FAIL right_first_x got %0d exp 321", bus.ghost_curr_pos_x);
      end
      repeat (14) tick(DIR_RIGHT);
      tests_run++;
      if (bus.prev_direction !== 4'b0010) begin
         tests_failed++; $display("FAIL right_prev_t15 got %b exp 0010", bus.prev_direction);
      end
      tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd336 || bus.ghost_curr_pos_y !== 10'd240) begin
         tests_failed++;
         $display("FAIL right_end_pos got (%0d,%0d) exp (336,240)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y);
      end
      tests_run++;
      if (bus.prev_direction !== 4'b0001) begin
         tests_failed++; $display("FAIL right_end_prev got %b exp 0001", bus.prev_direction);
      end
   endtask

   task automatic test_dir_change();
      repeat (4) tick(DIR_RIGHT);
      tick(DIR_UP);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd341 || bus.ghost_curr_pos_y !== 10'd240) begin
         tests_failed++;
         $display("FAIL chg_t5_pos got (%0d,%0d) exp (341,240)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y);
      end
      repeat (11) tick(DIR_UP);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd352 || bus.prev_direction !== 4'b0001) begin
         tests_failed++;
         $display("FAIL chg_tile_end got x=%0d prev=%b exp x=352 prev=0001",
                  bus.ghost_curr_pos_x, bus.prev_direction);
      end
      tick(DIR_UP);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd352 || bus.ghost_curr_pos_y !== 10'd239) begin
         tests_failed++;
         $display("FAIL chg_up_start got (%0d,%0d) exp (352,239)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y);
      end
      repeat (15) tick(DIR_UP);
      tests_run++;
      if (bus.ghost_curr_pos_y !== 10'd224 || bus.prev_direction !== 4'b0010) begin
         tests_failed++;
         $display("FAIL chg_up_end got y=%0d prev=%b exp y=224 prev=0010",
                  bus.ghost_curr_pos_y, bus.prev_direction);
      end
   endtask

   task automatic test_invalid_and_enable();
      repeat (10) tick(4'b0110);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd352 || bus.ghost_curr_pos_y !== 10'd224 ||
          bus.prev_direction !== 4'b0010) begin
         tests_failed++;
         $display("FAIL multihot got (%0d,%0d,%b) exp (352,224,0010)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y, bus.prev_direction);
      end
      repeat (10) tick(4'b0000);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd352 || bus.ghost_curr_pos_y !== 10'd224 ||
          bus.prev_direction !== 4'b0010) begin
         tests_failed++;
         $display("FAIL zerohot got (%0d,%0d,%b) exp (352,224,0010)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y, bus.prev_direction);
      end
      bus.enable = 1'b0;
      repeat (3) tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd352) begin
         tests_failed++; $display("FAIL disabled_x got %0d exp 352", bus.ghost_curr_pos_x);
      end
      bus.enable = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd352) begin
         tests_failed++; $display("FAIL no_queue_x got %0d exp 352", bus.ghost_curr_pos_x);
      end
      tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd353) begin
         tests_failed++; $display("FAIL reenable_x got %0d exp 353", bus.ghost_curr_pos_x);
      end
      repeat (15) tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd368 || bus.prev_direction !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reenable_end got x=%0d prev=%b exp x=368 prev=0001",
                  bus.ghost_curr_pos_x, bus.prev_direction);
      end
   endtask

   task automatic test_wrap();
      repeat (368) tick(DIR_LEFT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd0 || bus.prev_direction !== 4'b1000) begin
         tests_failed++;
         $display("FAIL wrap_reach0 got x=%0d prev=%b exp x=0 prev=1000",
                  bus.ghost_curr_pos_x, bus.prev_direction);
      end
      tick(DIR_LEFT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd639) begin
         tests_failed++; $display("FAIL wrap_left got %0d exp 639", bus.ghost_curr_pos_x);
      end
      repeat (15) tick(DIR_LEFT);
      repeat (15) tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd639) begin
         tests_failed++; $display("FAIL wrap_pre_right got %0d exp 639", bus.ghost_curr_pos_x);
      end
      tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd0 || bus.ghost_curr_pos_y !== 10'd224 ||
          bus.prev_direction !== 4'b0001) begin
         tests_failed++;
         $display("FAIL wrap_right got (%0d,%0d,%b) exp (0,224,0001)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y, bus.prev_direction);
      end
   endtask

   task automatic test_caught();
      @(negedge clk);
      bus.pacman_curr_pos_x = 11'd15;
      bus.pacman_curr_pos_y = 10'd224;
      #1;
      tests_run++;
      if (bus.caught !== 1'b0) begin
         tests_failed++; $display("FAIL caught_latency got %b exp 0", bus.caught);
      end
      @(negedge clk);
      tests_run++;
      if (bus.caught !== 1'b1) begin
         tests_failed++; $display("FAIL caught_dx15 got %b exp 1", bus.caught);
      end
      bus.pacman_curr_pos_x = 11'd16;
      @(negedge clk);
      tests_run++;
      if (bus.caught !== 1'b0) begin
         tests_failed++; $display("FAIL caught_dx16 got %b exp 0", bus.caught);
      end
      bus.pacman_curr_pos_x = 11'd0;
      bus.pacman_curr_pos_y = 10'd239;
      @(negedge clk);
      tests_run++;
      if (bus.caught !== 1'b1) begin
         tests_failed++; $display("FAIL caught_dy15 got %b exp 1", bus.caught);
      end
      bus.pacman_curr_pos_y = 10'd240;
      @(negedge clk);
      tests_run++;
      if (bus.caught !== 1'b0) begin
         tests_failed++; $display("FAIL caught_dy16 got %b exp 0", bus.caught);
      end
`ifdef GHOST_RESPAWN_EN
      repeat (59) tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd0 || bus.ghost_curr_pos_y !== 10'd224) begin
         tests_failed++;
         $display("FAIL respawn_frozen got (%0d,%0d) exp (0,224)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y);
      end
      tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd320 || bus.ghost_curr_pos_y !== 10'd240 ||
          bus.prev_direction !== 4'b0010) begin
         tests_failed++;
         $display("FAIL respawn_home got (%0d,%0d,%b) exp (320,240,0010)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y, bus.prev_direction);
      end
`else
      bus.pacman_curr_pos_x = 11'd15;
      bus.pacman_curr_pos_y = 10'd224;
      @(negedge clk);
      tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd1 || bus.caught !== 1'b1) begin
         tests_failed++;
         $display("FAIL caught_moves got x=%0d caught=%b exp x=1 caught=1",
                  bus.ghost_curr_pos_x, bus.caught);
      end
`endif
      bus.pacman_curr_pos_x = 11'd100;
      bus.pacman_curr_pos_y = 10'd600;
   endtask

   task automatic test_reset_mid_move();
      pos_x_t gx_exp;
      pos_y_t gy_exp;
`ifdef GHOST_RESPAWN_EN
      gx_exp = 11'd325;
      gy_exp = 10'd240;
`else
      gx_exp = 11'd6;
      gy_exp = 10'd224;
`endif
      repeat (5) tick(DIR_RIGHT);
      tests_run++;
      if (bus.ghost_curr_pos_x !== gx_exp || bus.ghost_curr_pos_y !== gy_exp) begin
         tests_failed++;
         $display("FAIL pre_reset_pos got (%0d,%0d) exp (%0d,%0d)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y, gx_exp, gy_exp);
      end
      bus.pacman_curr_pos_x = gx_exp;
      bus.pacman_curr_pos_y = gy_exp;
      @(negedge clk);
      reset              = 1'b1;
      bus.move_tick      = 1'b1;
      bus.move_direction = DIR_RIGHT;
      bus.pacman_curr_pos_x = 11'd320;
      bus.pacman_curr_pos_y = 10'd240;
      @(negedge clk);
      bus.move_tick = 1'b0;
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd320 || bus.ghost_curr_pos_y !== 10'd240 ||
          bus.prev_direction !== 4'b0010 || bus.caught !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_move got (%0d,%0d,%b,%b) exp (320,240,0010,0)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y, bus.prev_direction, bus.caught);
      end
      @(negedge clk);
      tests_run++;
      if (bus.caught !== 1'b0) begin
         tests_failed++; $display("FAIL reset_holds_caught got %b exp 0", bus.caught);
      end
      reset = 1'b0;
      bus.pacman_curr_pos_x = 11'd100;
      bus.pacman_curr_pos_y = 10'd600;
      tick(DIR_UP);
      tests_run++;
      if (bus.ghost_curr_pos_x !== 11'd320 || bus.ghost_curr_pos_y !== 10'd239) begin
         tests_failed++;
         $display("FAIL post_reset_up got (%0d,%0d) exp (320,239)",
                  bus.ghost_curr_pos_x, bus.ghost_curr_pos_y);
      end
   endtask

   initial begin
      tests_run             = 0;
      tests_failed          = 0;
      reset                 = 1'b1;
      bus.enable            = 1'b1;
      bus.move_tick         = 1'b0;
      bus.move_direction    = 4'b0000;
      bus.pacman_curr_pos_x = 11'd100;
      bus.pacman_curr_pos_y = 10'd600;

      test_reset();
      test_right_tile();
      test_dir_change();
      test_invalid_and_enable();
      test_wrap();
      test_caught();
      test_reset_mid_move();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_ghost_pos_update
